fetch_decode_ctrl: RTL and testbench

- Multi-cycle fetch/decode/sequencing controller for the 18-bit, 16-register processor.
- Fetches 18-bit instructions over a req/ack instruction-memory port and decodes them.
- Drives the register file's read/write addresses and write enable, plus ALU opcode, immediate and writeback select.
- Owns the PC, branch resolution and halt.
- Sits directly upstream of the register file; the ALU consumes the register file outputs combinationally.

---
 rtl/proc_pkg.sv | 55 +++++
 rtl/instr_decoder.sv | 57 +++++
 rtl/fetch_decode_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 18-bit, 16-register processor: opcodes, FSM states,
// ALU codes, instruction field positions and the decoded-control bundle.
package proc_pkg;

  localparam int INSTR_W = 18;
  localparam int REG_AW  = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;

  localparam int OPC_HI   = 17;
  localparam int OPC_LO   = 14;
  localparam int RD_HI    = 13;
  localparam int RD_LO    = 10;
  localparam int RS1_HI   = 9;
  localparam int RS1_LO   = 6;
  localparam int RS2_HI   = 5;
  localparam int RS2_LO   = 2;
  localparam int IMM6_HI  = 5;
  localparam int IMM10_HI = 9;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0]  addr1;
    logic [REG_AW-1:0]  addr2;
    logic [REG_AW-1:0]  wr_addr;
    logic [3:0]         alu_op;
    logic               alu_src_imm;
    logic [INSTR_W-1:0] imm;
    logic               wb_sel;
    logic               write;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode map: read-address select, ALU control, immediate
// extension, writeback select and register-write flag for one instruction word.
module instr_decoder
  import proc_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output decode_t            dec
);

  logic [3:0] opcode;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [5:0] imm6;
  logic [9:0] imm10;

  assign opcode = instr[OPC_HI:OPC_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign rs1    = instr[RS1_HI:RS1_LO];
  assign rs2    = instr[RS2_HI:RS2_LO];
  assign imm6   = instr[IMM6_HI:0];
  assign imm10  = instr[IMM10_HI:0];

  always_comb begin
    dec         = '0;
    dec.wr_addr = rd;
    dec.write   = (opcode <= OP_LDI);
    case (opcode)
      OP_ADD: begin dec.addr1 = rs1; dec.addr2 = rs2; dec.alu_op = ALU_ADD; end
      OP_SUB: begin dec.addr1 = rs1; dec.addr2 = rs2; dec.alu_op = ALU_SUB; end
      OP_AND: begin dec.addr1 = rs1; dec.addr2 = rs2; dec.alu_op = ALU_AND; end
      OP_OR:  begin dec.addr1 = rs1; dec.addr2 = rs2; dec.alu_op = ALU_OR;  end
      OP_XOR: begin dec.addr1 = rs1; dec.addr2 = rs2; dec.alu_op = ALU_XOR; end
      OP_ADDI: begin
        dec.addr1       = rs1;
        dec.addr2       = rs2;
        dec.alu_op      = ALU_ADD;
        dec.alu_src_imm = 1'b1;
        dec.imm         = {{(INSTR_W-6){imm6[5]}}, imm6};
      end
      OP_LDI: begin
        dec.imm    = {{(INSTR_W-10){1'b0}}, imm10};
        dec.wb_sel = 1'b1;
      end
      // Branch compares R[rd] with R[rs1] through a subtract; imm carries the offset.
      OP_BEQ: begin
        dec.addr1  = rd;
        dec.addr2  = rs1;
        dec.alu_op = ALU_SUB;
        dec.imm    = {{(INSTR_W-6){imm6[5]}}, imm6};
      end
      OP_JMP: dec.imm = {{(INSTR_W-10){1'b0}}, imm10};
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller: owns PC, instruction
// register, branch resolution and halt; decode outputs are derived from the IR.
module fetch_decode_ctrl
  import proc_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [3:0]        rf_read_addr1,
  output logic [3:0]        rf_read_addr2,
  output logic [3:0]        rf_write_addr,
  output logic              rf_write_enable,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic [DATA_W-1:0] imm_out,
  output logic              wb_sel,
  input  logic              alu_zero,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted
);

  // imem handshake: a fetch completes on the rising edge where imem_req and
  // imem_ack are both high; imem_ack at any other time has no effect.

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic              req_q;
  logic              we_q;
  logic              zero_q;
  logic              halted_q;
  logic [3:0]        opcode;
  logic [PC_W-1:0]   next_pc;
  decode_t           dec;

  // The IR only changes on a completed fetch, so every decoded output is
  // stable from DECODE through WRITEBACK and reads as zero after reset.
  instr_decoder u_dec (
    .instr (ir),
    .dec   (dec)
  );

  assign opcode = ir[OPC_HI:OPC_LO];

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (opcode == OP_BEQ && zero_q) begin
      next_pc = pc + dec.imm[PC_W-1:0];
    end else if (opcode == OP_JMP) begin
      next_pc = dec.imm[PC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      zero_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (req_q && imem_ack) begin
            ir    <= imem_rdata;
            req_q <= 1'b0;
            state <= S_DECODE;
          end else begin
            req_q <= 1'b1;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          zero_q <= alu_zero;
          we_q   <= dec.write;
          state  <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          we_q <= 1'b0;
          if (opcode == OP_HALT) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            pc    <= next_pc;
            req_q <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: begin
          req_q <= 1'b0;
          state <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_addr       = pc;
  assign pc_out          = pc;
  assign imem_req        = req_q;
  assign halted          = halted_q;
  assign rf_read_addr1   = dec.addr1;
  assign rf_read_addr2   = dec.addr2;
  assign rf_write_addr   = dec.wr_addr;
  assign alu_op          = dec.alu_op;
  assign alu_src_imm     = dec.alu_src_imm;
  assign imm_out         = dec.imm;
  assign wb_sel          = dec.wb_sel;
  // Reset on the closing edge of WRITEBACK must cancel the pending write.
  assign rf_write_enable = we_q & ~reset;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: vector table of single instructions plus
// hand sequences for fetch stalls, stray acks, reset in WRITEBACK and HALT.
module tb_fetch_decode_ctrl;

  logic        clk;
  logic        reset;
  logic [9:0]  imem_addr;
  logic        imem_req;
  logic [17:0] imem_rdata;
  logic        imem_ack;
  logic [3:0]  rf_read_addr1;
  logic [3:0]  rf_read_addr2;
  logic [3:0]  rf_write_addr;
  logic        rf_write_enable;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic [17:0] imm_out;
  logic        wb_sel;
  logic        alu_zero;
  logic [9:0]  pc_out;
  logic        halted;

  fetch_decode_ctrl #(.PC_W(10), .DATA_W(18)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .imem_ack        (imem_ack),
    .rf_read_addr1   (rf_read_addr1),
    .rf_read_addr2   (rf_read_addr2),
    .rf_write_addr   (rf_write_addr),
    .rf_write_enable (rf_write_enable),
    .alu_op          (alu_op),
    .alu_src_imm     (alu_src_imm),
    .imm_out         (imm_out),
    .wb_sel          (wb_sel),
    .alu_zero        (alu_zero),
    .pc_out          (pc_out),
    .halted          (halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [17:0] instr;
    logic        zero;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [3:0]  op;
    logic        src;
    logic [17:0] imm;
    logic        wb;
    logic        we;
    logic [3:0]  wr;
    logic [9:0]  pc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] cur_pc;
  int wcount;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    imem_req, 0);
    check({tag, "_pc"},     pc_out, 0);
    check({tag, "_addr"},   imem_addr, 0);
    check({tag, "_we"},     rf_write_enable, 0);
    check({tag, "_a1"},     rf_read_addr1, 0);
    check({tag, "_a2"},     rf_read_addr2, 0);
    check({tag, "_wr"},     rf_write_addr, 0);
    check({tag, "_op"},     alu_op, 0);
    check({tag, "_src"},    alu_src_imm, 0);
    check({tag, "_imm"},    imm_out, 0);
    check({tag, "_wb"},     wb_sel, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    cur_pc = '0;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_req_wait"}, imem_req, 1);
  endtask

  task automatic do_vec(input vec_t v, input int i);
    string t;
    t = $sformatf("v%0d", i);
    wait_req(t);
    check({t, "_imem_addr"}, imem_addr, cur_pc);
    imem_rdata = v.instr;
    imem_ack = 1'b1;
    @(negedge clk);  // DECODE
    imem_ack = 1'b0;
    imem_rdata = '0;
    check({t, "_dec_req"}, imem_req, 0);
    check({t, "_a1"}, rf_read_addr1, v.a1);
    check({t, "_a2"}, rf_read_addr2, v.a2);
    @(negedge clk);  // EXECUTE
    alu_zero = v.zero;
    check({t, "_op"}, alu_op, v.op);
    check({t, "_src"}, alu_src_imm, v.src);
    check({t, "_imm"}, imm_out, v.imm);
    check({t, "_ex_we"}, rf_write_enable, 0);
    @(negedge clk);  // WRITEBACK
    alu_zero = 1'b0;
    check({t, "_we"}, rf_write_enable, v.we);
    check({t, "_wr"}, rf_write_addr, v.wr);
    check({t, "_wb"}, wb_sel, v.wb);
    @(negedge clk);  // back in FETCH
    check({t, "_pc"}, pc_out, v.pc);
    check({t, "_post_we"}, rf_write_enable, 0);
    cur_pc = v.pc;
  endtask

  initial begin
    //            instr      z   a1  a2  op  src imm        wb  we  wr  pc
    vecs[0]  = '{18'h18D55, 0, 0,  0,  0, 0, 18'h00155, 1, 1, 3,  10'h001}; // LDI r3,#0x155
    vecs[1]  = '{18'h00490, 0, 2,  4,  0, 0, 18'h00000, 0, 1, 1,  10'h002}; // ADD r1,r2,r4
    vecs[2]  = '{18'h05E24, 0, 8,  9,  1, 0, 18'h00000, 0, 1, 7,  10'h003}; // SUB r7,r8,r9
    vecs[3]  = '{18'h0BC38, 0, 0,  14, 2, 0, 18'h00000, 0, 1, 15, 10'h004}; // AND r15,r0,r14
    vecs[4]  = '{18'h148FF, 0, 3,  15, 0, 1, 18'h3FFFF, 0, 1, 2,  10'h005}; // ADDI r2,r3,-1
    vecs[5]  = '{18'h1D5BE, 1, 5,  6,  1, 0, 18'h3FFFE, 0, 0, 5,  10'h003}; // BEQ taken -2
    vecs[6]  = '{18'h20005, 0, 0,  0,  0, 0, 18'h00005, 0, 0, 0,  10'h005}; // JMP 5
    vecs[7]  = '{18'h1D5BE, 0, 5,  6,  1, 0, 18'h3FFFE, 0, 0, 5,  10'h006}; // BEQ not taken
    vecs[8]  = '{18'h0D158, 0, 5,  6,  3, 0, 18'h00000, 0, 1, 4,  10'h007}; // OR r4,r5,r6
    vecs[9]  = '{18'h10048, 0, 1,  2,  4, 0, 18'h00000, 0, 1, 0,  10'h008}; // XOR r0,r1,r2
    vecs[10] = '{18'h27ABC, 0, 0,  0,  0, 0, 18'h00000, 0, 0, 14, 10'h009}; // NOP (op 9)
    vecs[11] = '{18'h1BFFF, 0, 0,  0,  0, 0, 18'h003FF, 1, 1, 15, 10'h00A}; // LDI r15,#0x3FF
    vecs[12] = '{18'h1445F, 0, 1,  7,  0, 1, 18'h0001F, 0, 1, 1,  10'h00B}; // ADDI r1,r1,+31
    vecs[13] = '{18'h203FF, 0, 0,  0,  0, 0, 18'h003FF, 0, 0, 0,  10'h3FF}; // JMP 0x3FF
    vecs[14] = '{18'h148FF, 0, 3,  15, 0, 1, 18'h3FFFF, 0, 1, 2,  10'h000}; // ADDI wraps pc
    vecs[15] = '{18'h1C03F, 1, 0,  0,  1, 0, 18'h3FFFF, 0, 0, 0,  10'h3FF}; // BEQ -1 at pc 0
    vecs[16] = '{18'h38000, 0, 0,  0,  0, 0, 18'h00000, 0, 0, 0,  10'h000}; // NOP (op E) wraps

    do_reset();
    @(negedge clk);
    check("req_after_reset", imem_req, 1);

    for (int i = 0; i < NV; i++) do_vec(vecs[i], i);

    // Fetch stall of 5 cycles, then a stray ack during EXECUTE.
    wait_req("stall");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_req", k), imem_req, 1);
      check($sformatf("stall%0d_addr", k), imem_addr, cur_pc);
    end
    wcount = 0;
    imem_rdata = 18'h00490;
    imem_ack = 1'b1;
    @(negedge clk);  // DECODE
    imem_ack = 1'b0;
    wcount += int'(rf_write_enable);
    check("stall_a1", rf_read_addr1, 2);
    @(negedge clk);  // EXECUTE
    wcount += int'(rf_write_enable);
    imem_rdata = 18'h1BFFF;
    imem_ack = 1'b1;
    @(negedge clk);  // WRITEBACK
    imem_ack = 1'b0;
    imem_rdata = '0;
    wcount += int'(rf_write_enable);
    check("stray_a1", rf_read_addr1, 2);
    check("stray_a2", rf_read_addr2, 4);
    check("stray_wr", rf_write_addr, 1);
    check("stray_wb", wb_sel, 0);
    @(negedge clk);  // FETCH
    wcount += int'(rf_write_enable);
    @(negedge clk);
    wcount += int'(rf_write_enable);
    check("stray_write_count", wcount, 1);
    check("stray_pc", pc_out, cur_pc + 10'd1);
    cur_pc = cur_pc + 10'd1;

    // Reset arriving during WRITEBACK of an ADDI suppresses the write.
    wait_req("rstwb");
    imem_rdata = 18'h148FF;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);  // WRITEBACK
    check("rstwb_we_before", rf_write_enable, 1);
    reset = 1'b1;
    #1;
    check("rstwb_we_gated", rf_write_enable, 0);
    @(negedge clk);
    check_reset_outputs("rstwb");
    reset = 1'b0;
    cur_pc = '0;
    @(negedge clk);
    check("rstwb_req_again", imem_req, 1);

    // HALT is absorbing until reset.
    do_vec(vecs[0], 100);
    wait_req("halt");
    imem_rdata = 18'h3C000;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);  // WRITEBACK
    check("halt_we", rf_write_enable, 0);
    check("halt_not_yet", halted, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      imem_ack = 1'b1;
      check($sformatf("halt%0d_halted", k), halted, 1);
      check($sformatf("halt%0d_req", k), imem_req, 0);
      check($sformatf("halt%0d_pc", k), pc_out, cur_pc);
    end
    imem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("halt_rst");
    reset = 1'b0;
    @(negedge clk);
    check("halt_rst_req", imem_req, 1);
    check("halt_rst_pc", pc_out, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
